bidir_xcvr: RTL

Parametrised, clocked bidirectional bus transceiver that connects two tri-state buses, `a_io` and `b_io`, of width `WIDTH`. A registered direction state machine enforces a programmable all-high-Z turnaround between direction changes so the two sides never drive at the same time. It is the next generation of the single-bit enable-controlled bidirectional buffer and sits between shared board-level or inter-block buses.

---
 rtl/bidir_pkg.sv | 23 ++
 rtl/bidir_turn_fsm.sv | 111 +++++++++++
 rtl/bidir_xcvr.sv | 71 +++++++
 3 files changed

// File: rtl/bidir_pkg.sv
// Shared types and constants for the bidirectional bus transceiver.
package bidir_pkg;

  // Direction state: both sides released, driving B, driving A, or enforced turnaround.
  typedef enum logic [1:0] {
    StHiz  = 2'd0,
    StAb   = 2'd1,
    StBa   = 2'd2,
    StTurn = 2'd3
  } xcvr_state_e;

  localparam logic DIR_AB = 1'b1;  // drive b_io from a_io
  localparam logic DIR_BA = 1'b0;  // drive a_io from b_io

  // State selected from an idle position (HIZ, or the last TURN cycle).
  function automatic xcvr_state_e req_state(input logic en, input logic dir);
    if (!en) begin
      return StHiz;
    end
    return (dir == DIR_BA) ? StBa : StAb;
  endfunction

endpackage

// File: rtl/bidir_turn_fsm.sv
// Direction state machine with turnaround counter and status outputs.
// Build option BIDIR_XCVR_REG_EN: valid_o only rises on the second consecutive cycle
// of a drive state, because the first cycle drives stale registered data.
module bidir_turn_fsm #(
  parameter int unsigned TURN_CYC = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic dir,
  output logic drv_ab_o,
  output logic drv_ba_o,
  output logic turn_o,
  output logic valid_o
);
  import bidir_pkg::*;

  // Guard keeps the width legal so the elaboration error below is the reported problem.
  localparam int unsigned CntW = (TURN_CYC > 0) ? $clog2(TURN_CYC + 1) : 1;
  localparam logic [CntW-1:0] TurnLoad = CntW'(TURN_CYC);
  localparam logic [CntW-1:0] CntOne   = CntW'(1);

  if (TURN_CYC == 0) begin : g_turn_cyc_check
    $error("bidir_turn_fsm: TURN_CYC must be at least 1");
  end

  xcvr_state_e     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

`ifdef BIDIR_XCVR_REG_EN
  logic valid_q, valid_d;
`endif

  // State, counter and valid registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StHiz;
      cnt_q   <= '0;
`ifdef BIDIR_XCVR_REG_EN
      valid_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
`ifdef BIDIR_XCVR_REG_EN
      valid_q <= valid_d;
`endif
    end
  end

  // Next state: every drive exit goes through TURN; inputs only matter at TURN's last cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StHiz: begin
        state_d = req_state(en, dir);
      end
      StAb: begin
        if (!(en && (dir == DIR_AB))) begin
          state_d = StTurn;
          cnt_d   = TurnLoad;
        end
      end
      StBa: begin
        if (!(en && (dir == DIR_BA))) begin
          state_d = StTurn;
          cnt_d   = TurnLoad;
        end
      end
      StTurn: begin
        // <= rather than == so a corrupted zero count still leaves TURN instead of wrapping.
        if (cnt_q <= CntOne) begin
          state_d = req_state(en, dir);
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      default: begin
        state_d = StHiz;
        cnt_d   = '0;
      end
    endcase
`ifdef BIDIR_XCVR_REG_EN
    valid_d = 1'b0;
    if ((state_q == StAb) || (state_q == StBa)) begin
      valid_d = (state_d == state_q);
    end
`endif
  end

  // Driver enables and status decoded from the state register only.
  always_comb begin
    drv_ab_o = 1'b0;
    drv_ba_o = 1'b0;
    turn_o   = 1'b0;
    unique case (state_q)
      StAb:    drv_ab_o = 1'b1;
      StBa:    drv_ba_o = 1'b1;
      StTurn:  turn_o   = 1'b1;
      default: ;
    endcase
`ifdef BIDIR_XCVR_REG_EN
    valid_o = valid_q;
`else
    valid_o = drv_ab_o | drv_ba_o;
`endif
  end

endmodule

// File: rtl/bidir_xcvr.sv
// Clocked bidirectional transceiver between tri-state buses a_io and b_io.
// Build option BIDIR_XCVR_REG_EN: registered data path (1-cycle data latency);
// otherwise the selected bus is a combinational copy of the source side.
module bidir_xcvr #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned TURN_CYC = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             dir,
  inout  wire  [WIDTH-1:0] a_io,
  inout  wire  [WIDTH-1:0] b_io,
  output logic             drv_ab_o,
  output logic             drv_ba_o,
  output logic             turn_o,
  output logic             valid_o
);
  import bidir_pkg::*;

  if (WIDTH == 0) begin : g_width_check
    $error("bidir_xcvr: WIDTH must be at least 1");
  end

  logic             drv_ab;
  logic             drv_ba;
  logic [WIDTH-1:0] a_out;
  logic [WIDTH-1:0] b_out;

  bidir_turn_fsm #(
    .TURN_CYC(TURN_CYC)
  ) u_fsm (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .dir     (dir),
    .drv_ab_o(drv_ab),
    .drv_ba_o(drv_ba),
    .turn_o  (turn_o),
    .valid_o (valid_o)
  );

  assign drv_ab_o = drv_ab;
  assign drv_ba_o = drv_ba;

`ifdef BIDIR_XCVR_REG_EN
  logic [WIDTH-1:0] data_q;

  // Capture the source side while driving; hold through TURN and HIZ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (drv_ab) begin
      data_q <= a_io;
    end else if (drv_ba) begin
      data_q <= b_io;
    end
  end

  assign a_out = data_q;
  assign b_out = data_q;
`else
  assign a_out = b_io;
  assign b_out = a_io;
`endif

  // Source side is never driven; both released unless the state says otherwise.
  assign a_io = drv_ba ? a_out : {WIDTH{1'bz}};
  assign b_io = drv_ab ? b_out : {WIDTH{1'bz}};

endmodule
